// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the LEGv8 PC sequencer.
package pc_sequencer_pkg;

  localparam int unsigned DEFAULT_STEP         = 4;
  localparam int unsigned DEFAULT_RESET_VECTOR = 0;
  localparam int unsigned STATE_W              = 3;

  typedef enum logic [STATE_W-1:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StIssue  = 3'd2,
    StHalted = 3'd3,
    StError  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PcHold   = 2'd0,
    PcInc    = 2'd1,
    PcBranch = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC select: hold, sequential step, or step-aligned branch target.
module pc_next_logic
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned STEP       = DEFAULT_STEP
) (
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  pc_sel_e               i_sel,
  input  logic [ADDR_WIDTH-1:0] i_target,
  output logic [ADDR_WIDTH-1:0] o_pc_next
);

  localparam logic [ADDR_WIDTH-1:0] StepVal   = ADDR_WIDTH'(STEP);
  // STEP is a power of two, so this clears the low log2(STEP) bits.
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~(StepVal - 1'b1);

  always_comb begin
    o_pc_next = i_pc;
    unique case (i_sel)
      PcInc:    o_pc_next = i_pc + StepVal;
      PcBranch: o_pc_next = i_target & AlignMask;
      default:  o_pc_next = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch/issue FSM and fetch-acknowledge timeout for the LEGv8 front end.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned STEP         = DEFAULT_STEP,
  parameter int unsigned RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  output logic                  o_fetch_req,
  output logic [ADDR_WIDTH-1:0] o_fetch_addr,
  input  logic                  i_fetch_ack,
  output logic                  o_instr_valid,
  input  logic                  i_stall,
  input  logic                  i_branch_taken,
  input  logic [ADDR_WIDTH-1:0] i_branch_target,
  input  logic                  i_halt,
  output logic [ADDR_WIDTH-1:0] o_pc_out,
  output logic                  o_halted,
  output logic                  o_fetch_err
);

  localparam int unsigned           CntW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0]       TimeoutVal = CntW'(ACK_TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] ResetPc    = ADDR_WIDTH'(RESET_VECTOR);

  state_e                r_state, w_state_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
  pc_sel_e               w_pc_sel;
  logic                  r_fetch_req, r_instr_valid, r_halted, r_fetch_err;

  pc_next_logic #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .STEP      (STEP)
  ) u_pc_next (
    .i_pc     (r_pc),
    .i_sel    (w_pc_sel),
    .i_target (i_branch_target),
    .o_pc_next(w_pc_next)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pc_sel  = PcHold;
    unique case (r_state)
      StIdle: w_state_d = StFetch;
      StFetch: begin
        // halt is deliberately not looked at while a request is outstanding
        if (i_fetch_ack) begin
          w_state_d = StIssue;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
          if (w_cnt_d == TimeoutVal) w_state_d = StError;
        end
      end
      StIssue: begin
        if (!i_stall) begin
          if (i_halt) begin
            w_state_d = StHalted;
          end else begin
            w_state_d = StFetch;
            w_pc_sel  = i_branch_taken ? PcBranch : PcInc;
          end
        end
      end
      StHalted, StError: w_state_d = r_state;
      default:           w_state_d = StError;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with r_state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_pc          <= ResetPc;
      r_fetch_req   <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_pc          <= w_pc_next;
      r_fetch_req   <= (w_state_d == StFetch);
      r_instr_valid <= (w_state_d == StIssue);
      r_halted      <= (w_state_d == StHalted);
      r_fetch_err   <= (w_state_d == StError);
    end
  end

  assign o_fetch_req   = r_fetch_req;
  assign o_fetch_addr  = r_pc;
  assign o_pc_out      = r_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_halted      = r_halted;
  assign o_fetch_err   = r_fetch_err;

endmodule
